nth_root_iter: RTL and testbench
================================

Name: nth_root_iter

Overview:
- Parametrised, handshaked n-th root unit: out = floor(x^(1/n)) in fixed point, IN_W integer bits and FRAC_W fraction bits.
- Bit-serial binary search, MSB first. Candidate powers are built with one shared multiplier, one multiply per cycle, with no combinational power operator.
- Adds input/output ready/valid backpressure, exact-root and error flags, and fast paths for n=0, n=1 and x=0.
- Sits in the arithmetic datapath beside the divider blocks.

Parameters:
- IN_W, 10, radicand width (unsigned integer).
- FRAC_W, 10, fraction bits of the result.
- EXP_W, 3, exponent width; MAX_N = 2^EXP_W-1.
- Derived OUT_W = IN_W+FRAC_W; P_W = MAX_N*OUT_W (power accumulator width).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request (IDLE only).
- in_data_1  in  IN_W  radicand x.
- in_data_2  in  EXP_W  root order n.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  root, Q(IN_W).(FRAC_W), truncated (floor).
- out_exact  out  1  out_data^n equals x<<(n*FRAC_W) exactly.
- out_err  out  1  n==0 request.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - out_valid=0, out_data=0, out_exact=0, out_err=0.
  - Internal regs cleared; in_ready=1 after release.
  - Reset mid-operation aborts the job; no output is produced.
- in_ready = (state==IDLE), combinational from the state register. Accept = in_valid&&in_ready; x and n are latched on accept. Inputs are ignored in all other states.
- States:
  - IDLE: on accept, res<=0, bit<=OUT_W-1, exact<=0, err<=0.
    - Priority: n==0 -> err<=1, res<=0 -> DONE.
    - Else n==1 -> res<=x<<FRAC_W, exact<=1 -> DONE.
    - Else x==0 -> res<=0, exact<=1 -> DONE.
    - Else acc<=cand, k<=1 -> POW.
  - cand = res | (1<<bit), combinational. T = x<<(n*FRAC_W), P_W bits.
  - POW: acc<=acc*cand (truncation not allowed; P_W covers the full product); k<=k+1. Go to CMP when k+1==n, i.e. n-1 POW cycles per bit.
  - CMP, acc compared with T:
    - acc<T: res<=cand.
    - acc==T: res<=cand, exact<=1 -> DONE (early terminate; the remaining bits are zero).
    - acc>T: res unchanged.
    - If not terminated: bit==0 -> DONE; else bit<=bit-1, acc<=next candidate (built from the updated res), k<=1 -> POW.
  - DONE: out_valid=1. out_data, out_exact and out_err are registered and stable while out_valid=1. On out_valid&&out_ready -> IDLE, with out_valid=0 the next cycle. out_ready low holds DONE indefinitely.
- Latency, accept edge to out_valid high:
  - General case: OUT_W*n+1 cycles.
  - Exact match at bit index b: (OUT_W-b)*n+1 cycles.
  - Fast paths: 1 cycle.
- Throughput: one job in flight; a new accept is earliest in the cycle after the output handshake.
- out_valid and in_ready are never both 1.

Test Plan:
- x=2, n=2, out_ready=1 -> out_data=0x005A8 (1448), exact=0, err=0; out_valid rises 41 cycles after accept, high exactly 1 cycle.
- x=8, n=3 -> out_data=0x00800, exact=1; early terminate at bit 11, out_valid 28 cycles after accept.
- x=1000, n=7 -> out_data=0x00ABB (2747), exact=0, latency 141. Checks the full 140-bit accumulator path with no overflow.
- Fast paths, each with out_valid 1 cycle after accept:
  - x=1023, n=1 -> out_data=0xFFC00, exact=1.
  - x=0, n=5 -> out_data=0, exact=1.
  - x=37, n=0 -> out_data=0, err=1, exact=0.
- Backpressure: x=2, n=2 with out_ready low for 5 cycles after out_valid rises.
  - out_valid, out_data=0x005A8 and in_ready=0 all held.
  - in_valid pulses with x=9 in this window are ignored.
  - Handshake -> IDLE; the next request x=9, n=2 gives 0x00C00, exact=1.
- Assert rst_n low asynchronously (between clock edges) midway through x=1000, n=7.
  - Outputs zero immediately; out_valid never rises.
  - After release, x=2, n=2 returns 0x005A8 with normal latency.

Source files
------------

// File: rtl/nth_root_iter_if.sv
// Request/response bundle for the nth_root_iter block.
//   in_valid/in_ready   request handshake, in_data_1 = radicand x, in_data_2 = root order n
//   out_valid/out_ready response handshake, out_data = floor root Q(IN_W).(FRAC_W),
//   out_exact = root is exact, out_err = n was zero
// master drives requests and consumes results; slave is the arithmetic unit.
interface nth_root_iter_if #(
  parameter int unsigned IN_W   = 10,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned EXP_W  = 3
);
  localparam int unsigned OUT_W = IN_W + FRAC_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data_1;
  logic [EXP_W-1:0] in_data_2;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_exact;
  logic             out_err;

  modport master (
    output in_valid, in_data_1, in_data_2, out_ready,
    input  in_ready, out_valid, out_data, out_exact, out_err
  );

  modport slave (
    input  in_valid, in_data_1, in_data_2, out_ready,
    output in_ready, out_valid, out_data, out_exact, out_err
  );
endinterface

// File: rtl/nth_root_iter.sv
// Handshaked fixed-point n-th root: out = floor(x^(1/n)), IN_W integer and FRAC_W fraction bits.
// Bit-serial binary search, MSB first. Each candidate power is built by repeated
// multiplication through one shared multiplier (one multiply per cycle).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nth_root_iter_if.slave (request in_*, response out_*)
module nth_root_iter #(
  parameter int unsigned IN_W   = 10,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned EXP_W  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  nth_root_iter_if.slave bus
);
  localparam int unsigned MAX_N = (1 << EXP_W) - 1;
  localparam int unsigned OUT_W = IN_W + FRAC_W;
  localparam int unsigned P_W   = MAX_N * OUT_W;
  localparam int unsigned BIT_W = $clog2(OUT_W);

  typedef enum logic [1:0] {StIdle, StPow, StCmp, StDone} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic [EXP_W-1:0] n_q, n_d;
  logic [EXP_W-1:0] k_q, k_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic             exact_q, exact_d;
  logic             err_q, err_d;

  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] res_upd;
  logic [OUT_W-1:0] cand_next;
  logic [P_W-1:0]   tgt;
  logic [P_W-1:0]   prod;
  logic [EXP_W:0]   k_inc;

  // Datapath: candidate, scaled radicand and the shared multiplier.
  always_comb begin
    cand      = res_q | (OUT_W'(1) << bit_idx_q);
    tgt       = P_W'(x_q) << (32'(n_q) * FRAC_W);
    // P_W holds cand^MAX_N in full, so this product never loses bits.
    prod      = acc_q * P_W'(cand);
    res_upd   = (acc_q <= tgt) ? cand : res_q;
    // Next candidate derives from the post-compare result, not res_q.
    cand_next = res_upd | (OUT_W'(1) << (bit_idx_q - BIT_W'(1)));
    k_inc     = {1'b0, k_q} + (EXP_W + 1)'(1);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    n_d       = n_q;
    k_d       = k_q;
    res_d     = res_q;
    bit_idx_d = bit_idx_q;
    acc_d     = acc_q;
    exact_d   = exact_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          x_d       = bus.in_data_1;
          n_d       = bus.in_data_2;
          res_d     = '0;
          bit_idx_d = BIT_W'(OUT_W - 1);
          exact_d   = 1'b0;
          err_d     = 1'b0;
          if (bus.in_data_2 == '0) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (bus.in_data_2 == EXP_W'(1)) begin
            res_d   = OUT_W'(bus.in_data_1) << FRAC_W;
            exact_d = 1'b1;
            state_d = StDone;
          end else if (bus.in_data_1 == '0) begin
            exact_d = 1'b1;
            state_d = StDone;
          end else begin
            acc_d   = P_W'(1) << (OUT_W - 1);
            k_d     = EXP_W'(1);
            state_d = StPow;
          end
        end
      end

      StPow: begin
        acc_d = prod;
        k_d   = k_inc[EXP_W-1:0];
        if (k_inc == {1'b0, n_q}) state_d = StCmp;
      end

      StCmp: begin
        if (acc_q == tgt) begin
          // Exact root found: every lower bit is zero, stop early.
          res_d   = cand;
          exact_d = 1'b1;
          state_d = StDone;
        end else begin
          res_d = res_upd;
          if (bit_idx_q == '0) begin
            state_d = StDone;
          end else begin
            bit_idx_d = bit_idx_q - BIT_W'(1);
            acc_d     = P_W'(cand_next);
            k_d       = EXP_W'(1);
            state_d   = StPow;
          end
        end
      end

      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      res_q     <= '0;
      bit_idx_q <= '0;
      acc_q     <= '0;
      exact_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      n_q       <= n_d;
      k_q       <= k_d;
      res_q     <= res_d;
      bit_idx_q <= bit_idx_d;
      acc_q     <= acc_d;
      exact_q   <= exact_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = res_q;
  assign bus.out_exact = exact_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_nth_root_iter.sv
// Scoreboard bench for nth_root_iter: the driver pushes modelled results, a monitor
// pops and compares whenever out_valid rises, and checks hold behaviour while stalled.
module tb_nth_root_iter;
  localparam int unsigned IN_W   = 10;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned EXP_W  = 3;
  localparam int unsigned OUT_W  = IN_W + FRAC_W;

  typedef struct {
    logic [OUT_W-1:0] data;
    bit               exact;
    bit               err;
    int               lat;
    int               acc_edge;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   bp_rand = 0;
  logic dir_ready = 1'b1;
  logic rnd_ready = 1'b1;
  exp_t sb[$];

  nth_root_iter_if #(.IN_W(IN_W), .FRAC_W(FRAC_W), .EXP_W(EXP_W)) bus ();

  nth_root_iter #(.IN_W(IN_W), .FRAC_W(FRAC_W), .EXP_W(EXP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.out_ready = bp_rand ? rnd_ready : dir_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [159:0] ipow(input logic [159:0] b, input int n);
    logic [159:0] p = 160'd1;
    for (int i = 0; i < n; i++) p = p * b;
    return p;
  endfunction

  // Floor root from a real-valued estimate, corrected with exact wide integer powers.
  function automatic exp_t model(input int x, input int n);
    exp_t         e;
    logic [159:0] tgt;
    int           r;
    int           tz;
    e.data = '0; e.exact = 0; e.err = 0; e.lat = 1; e.acc_edge = 0;
    if (n == 0) begin
      e.err = 1;
    end else if (n == 1) begin
      e.data  = OUT_W'(x) << FRAC_W;
      e.exact = 1;
    end else if (x == 0) begin
      e.exact = 1;
    end else begin
      tgt = 160'(x) << (n * FRAC_W);
      r   = $rtoi($pow(real'(x), 1.0 / real'(n)) * real'(1 << FRAC_W));
      while (ipow(160'(r + 1), n) <= tgt) r++;
      while (ipow(160'(r), n) > tgt) r--;
      e.data  = OUT_W'(r);
      e.exact = (ipow(160'(r), n) == tgt);
      if (e.exact) begin
        tz = 0;
        while (((r >> tz) & 1) == 0) tz++;
        e.lat = (OUT_W - tz) * n + 1;
      end else begin
        e.lat = OUT_W * n + 1;
      end
    end
    return e;
  endfunction

  task automatic send(input int x, input int n, input bit push);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.in_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
      return;
    end
    bus.in_valid  = 1'b1;
    bus.in_data_1 = IN_W'(x);
    bus.in_data_2 = EXP_W'(n);
    if (push) begin
      e          = model(x, n);
      e.acc_edge = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || bus.out_valid) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor
  bit   prev_valid = 0;
  bit   hs_last = 0;
  exp_t cur;

  always @(posedge clk) hs_last = bus.out_valid && bus.out_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
    end else begin
      if (bus.out_valid && bus.in_ready) check("valid_and_ready", 64'd1, 64'd0);
      if (bus.out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(bus.out_data), 64'd0);
          cur.data = bus.out_data; cur.exact = bus.out_exact; cur.err = bus.out_err;
        end else begin
          cur = sb.pop_front();
          check("out_data", 64'(bus.out_data), 64'(cur.data));
          check("out_exact", 64'(bus.out_exact), 64'(cur.exact));
          check("out_err", 64'(bus.out_err), 64'(cur.err));
          check("latency", 64'(cyc - cur.acc_edge + 1), 64'(cur.lat));
        end
      end else if (bus.out_valid && prev_valid) begin
        if (hs_last) check("valid_after_handshake", 64'd1, 64'd0);
        check("hold_data", 64'(bus.out_data), 64'(cur.data));
        check("hold_flags", {62'd0, bus.out_exact, bus.out_err}, {62'd0, cur.exact, cur.err});
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    int guard;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data_1 = '0;
    bus.in_data_2 = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_flags", {62'd0, bus.out_exact, bus.out_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed cases, including every fast path.
    send(2, 2, 1);
    send(8, 3, 1);
    send(1000, 7, 1);
    send(1023, 1, 1);
    send(0, 5, 1);
    send(37, 0, 1);
    drain();

    // Backpressure with ignored requests while the result is stalled.
    dir_ready = 1'b0;
    send(2, 2, 1);
    guard = 0;
    while (!bus.out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("bp_valid_rise", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_data", 64'(bus.out_data), 64'h005A8);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid  = (i % 2 == 0);
      bus.in_data_1 = IN_W'(9);
      bus.in_data_2 = EXP_W'(2);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    dir_ready    = 1'b1;
    send(9, 2, 1);
    drain();

    // Randomised jobs with random consumer stalls.
    bp_rand = 1;
    for (int j = 0; j < 30; j++) begin
      int x;
      int n;
      x = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
      n = int'($urandom_range(0, 7));
      send(x, n, 1);
    end
    drain();
    bp_rand = 0;

    // Asynchronous reset in the middle of a long job.
    send(1000, 7, 0);
    repeat (60) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_data", 64'(bus.out_data), 64'd0);
    check("abort_flags", {62'd0, bus.out_exact, bus.out_err}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (bus.out_valid) check("abort_no_output", 64'(bus.out_valid), 64'd0);
    end
    send(2, 2, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
